// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        WAIT_SPACE = 2'd1,
        DRAIN      = 2'd2
    } fetch_state_t;

    localparam int          INSTR_W          = 32;
    localparam int          ADDR_W           = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with flush and a registered head.
module fetch_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [CNT_W-1:0]  count,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_next;
    logic [CNT_W-1:0]  kept;
    logic [CNT_W-1:0]  count_next;

    assign kept       = count - CNT_W'(pop);
    assign count_next = kept + CNT_W'(push);
    assign rd_next    = rd_ptr + PTR_W'(pop);

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Head register looks one edge ahead: a push into an empty (or emptying) FIFO lands directly in it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            rd_ptr     <= rd_next;
            wr_ptr     <= wr_ptr + PTR_W'(push);
            count      <= count_next;
            head_valid <= (count_next != '0);
            if (kept == '0) begin
                if (push) begin
                    head_data <= wdata;
                end
            end else begin
                head_data <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack, instruction buffer and redirect/flush.
// Optional macro FETCH_PERF_EN adds bubble and flush performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubbles,
    output logic [15:0] perf_flushes
`endif
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int               ENTRY_W = ADDR_W + INSTR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_t        state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   redirect_target;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    occ_kept;
    logic [CNT_W-1:0]    occ_next;
    logic [ENTRY_W-1:0]  head_data;

    assign pc_inc          = next_pc(pc);
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign push            = !redirect_valid && (state == FETCH) && imem_req && imem_ack;
    assign pop             = instr_valid && instr_ready;
    assign occ_kept        = count - CNT_W'(pop);
    assign occ_next        = occ_kept + CNT_W'(push);

    fetch_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .wdata      ({pc, imem_rdata}),
        .count      (count),
        .head_valid (instr_valid),
        .head_data  (head_data)
    );

    assign instr_pc = head_data[ENTRY_W-1:INSTR_W];
    assign instr    = head_data[INSTR_W-1:0];

    // imem_addr only diverges from pc while draining a request orphaned by a redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_target;
            if (imem_req && !imem_ack) begin
                state <= DRAIN;
            end else begin
                state     <= FETCH;
                imem_req  <= 1'b1;
                imem_addr <= redirect_target;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    if (!imem_req) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end else if (imem_ack) begin
                        pc        <= pc_inc;
                        imem_addr <= pc_inc;
                        if (occ_next >= DEPTH_C) begin
                            state    <= WAIT_SPACE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                WAIT_SPACE: begin
                    if (occ_kept < DEPTH_C) begin
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state     <= FETCH;
                        imem_addr <= pc;
                    end
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_bubbles <= '0;
            perf_flushes <= '0;
        end else begin
            if (instr_ready && !instr_valid && (perf_bubbles != 32'hFFFF_FFFF)) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushes <= perf_flushes + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed scenarios.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack, redirect_valid, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

    logic        w_req, w_ack, w_redir, w_valid, w_ready;
    logic [31:0] w_addr, w_rdata, w_rpc, w_instr, w_pc;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .redirect_valid(w_redir), .redirect_pc(w_rpc),
        .instr_valid(w_valid), .instr_ready(w_ready), .instr(w_instr), .instr_pc(w_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc, m_addr;
    bit          m_req, m_drain;

    int          lat_mode = 0;
    int          lat_cur  = 0;
    int          wait_cnt = 0;
    bit          garbage  = 1'b0;
    logic [31:0] issued_q[$];
    logic [31:0] popped_pc_q[$];
    logic [31:0] popped_ins_q[$];
    logic [31:0] w_addrs[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc    = 32'h0;
        m_addr  = 32'h0;
        m_req   = 1'b0;
        m_drain = 1'b0;
    endtask

    // One clock of the architectural fetch behaviour, from the inputs seen before the edge.
    task automatic model_step();
        bit          acked;
        bit          popped;
        logic [31:0] target;
        acked  = m_req && imem_ack;
        popped = (m_q.size() != 0) && instr_ready;
        if (redirect_valid) begin
            m_q.delete();
            target = redirect_pc & 32'hFFFF_FFFC;
            m_pc   = target;
            if (m_req && !acked) begin
                m_drain = 1'b1;
            end else begin
                m_drain = 1'b0;
                m_req   = 1'b1;
                m_addr  = target;
            end
            return;
        end
        if (m_drain) begin
            if (acked) begin
                m_drain = 1'b0;
                m_addr  = m_pc;
            end
            return;
        end
        if (popped) void'(m_q.pop_front());
        if (acked) begin
            m_q.push_back('{pc: m_pc, ins: mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
        end
        m_req  = (m_q.size() < DEPTH);
        m_addr = m_pc;
    endtask

    task automatic compare();
        chk("imem_req", imem_req, m_req);
        if (m_req) chk("imem_addr", imem_addr, m_addr);
        chk("instr_valid", instr_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("instr", instr, m_q[0].ins);
            chk("instr_pc", instr_pc, m_q[0].pc);
        end
    endtask

    task automatic respond();
        if (imem_req && !reset) begin
            if (wait_cnt >= lat_cur) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                issued_q.push_back(imem_addr);
                wait_cnt   = 0;
                lat_cur    = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            imem_ack   = garbage;
            imem_rdata = $urandom;
            wait_cnt   = 0;
        end
    endtask

    task automatic cycle();
        respond();
        if (instr_valid && instr_ready && !redirect_valid && !reset) begin
            popped_pc_q.push_back(instr_pc);
            popped_ins_q.push_back(instr);
        end
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        model_reset();
        wait_cnt = 0;
        lat_cur  = (lat_mode < 0) ? 0 : lat_mode;
        issued_q.delete();
        popped_pc_q.delete();
        popped_ins_q.delete();
        #1;
        chk("rst_req", imem_req, 32'd0);
        chk("rst_valid", instr_valid, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        w_ack   = w_req;
        w_rdata = mem_word(w_addr);
        if (w_req === 1'b1 && !reset) w_addrs.push_back(w_addr);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int hits;
        w_ready = 1'b1; w_redir = 1'b0; w_rpc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        instr_ready = 1'b1;
        @(negedge clk);

        // Zero-wait memory, decode always ready.
        lat_mode = 0; instr_ready = 1'b1; garbage = 1'b0;
        do_reset();
        n = 0;
        while (popped_pc_q.size() < 4 && n < 30) begin cycle(); n++; end
        chk("t1_pops_seen", popped_pc_q.size() >= 4, 32'd1);
        if (issued_q.size() >= 4 && popped_pc_q.size() >= 4) begin
            chk("t1_addr0", issued_q[0], 32'h0);
            chk("t1_addr1", issued_q[1], 32'h4);
            chk("t1_addr2", issued_q[2], 32'h8);
            chk("t1_addr3", issued_q[3], 32'hC);
            chk("t1_pc0", popped_pc_q[0], 32'h0);
            chk("t1_pc3", popped_pc_q[3], 32'hC);
            chk("t1_ins0", popped_ins_q[0], 32'h1234_5678);
            chk("t1_ins1", popped_ins_q[1], 32'h6AE9_B0BC);
        end
        chk("t5_wrap_seen", w_addrs.size() >= 3, 32'd1);
        if (w_addrs.size() >= 3) begin
            chk("t5_wrap0", w_addrs[0], 32'hFFFF_FFF8);
            chk("t5_wrap1", w_addrs[1], 32'hFFFF_FFFC);
            chk("t5_wrap2", w_addrs[2], 32'h0000_0000);
        end

        // Decode stalled: FIFO fills, fetch parks, then resumes at 8.
        instr_ready = 1'b0;
        do_reset();
        repeat (8) cycle();
        chk("t2_pushes", issued_q.size(), 32'd2);
        chk("t2_req_low", imem_req, 32'd0);
        chk("t2_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!imem_req && n < 2);
        chk("t2_resume_req", imem_req, 32'd1);
        chk("t2_resume_addr", imem_addr, 32'h8);

        // Redirect while a slow request is outstanding.
        lat_mode = 3; instr_ready = 1'b1;
        do_reset();
        n = 0;
        while (!(imem_req && imem_addr == 32'h10) && n < 80) begin cycle(); n++; end
        chk("t3_reached_10", imem_addr, 32'h10);
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        popped_pc_q.delete();
        chk("t3_drain_req", imem_req, 32'd1);
        chk("t3_drain_addr", imem_addr, 32'h10);
        n = 0;
        while (imem_addr == 32'h10 && n < 10) begin cycle(); n++; end
        chk("t3_next_req", imem_req, 32'd1);
        chk("t3_next_addr", imem_addr, 32'h40);
        repeat (20) cycle();
        hits = 0;
        foreach (popped_pc_q[i]) if (popped_pc_q[i] == 32'h10) hits++;
        chk("t3_no_stale", hits, 32'd0);
        if (popped_pc_q.size() > 0) chk("t3_first_pc", popped_pc_q[0], 32'h40);
        else chk("t3_first_pc_seen", 32'd0, 32'd1);

        // Redirect coinciding with an ack.
        lat_mode = 0; instr_ready = 1'b1;
        do_reset();
        repeat (5) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        cycle();
        redirect_valid = 1'b0;
        popped_pc_q.delete();
        chk("t4_empty", instr_valid, 32'd0);
        chk("t4_req", imem_req, 32'd1);
        chk("t4_addr", imem_addr, 32'h100);
        n = 0;
        while (popped_pc_q.size() == 0 && n < 10) begin cycle(); n++; end
        if (popped_pc_q.size() > 0) chk("t4_first_pc", popped_pc_q[0], 32'h100);
        else chk("t4_first_pc_seen", 32'd0, 32'd1);

        // Reset mid-operation with a stray ack around release.
        lat_mode = 0; instr_ready = 1'b0;
        do_reset();
        repeat (6) cycle();
        lat_mode = 6; lat_cur = 6;
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        cycle();
        chk("t6_pre_req", imem_req, 32'd1);
        lat_mode = 0; garbage = 1'b1;
        do_reset();
        cycle();
        garbage = 1'b0;
        chk("t6_req", imem_req, 32'd1);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_valid", instr_valid, 32'd0);
        cycle();
        chk("t6_first_pc", instr_pc, 32'h0);
        chk("t6_first_ins", instr, 32'h1234_5678);

        // Randomized traffic against the model.
        lat_mode = -1;
        do_reset();
        for (int c = 0; c < 1600; c++) begin
            instr_ready    = (c < 800) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            garbage        = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cycle();
        end
        redirect_valid = 1'b0;
        garbage = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
